// File: rtl/mv_pixel_loader_if.sv
// ============================================================================
// Module   : mv_pixel_loader_if
// Brief    : Pixel-stream, block-handshake and read-port bundle for the loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mv_pixel_loader_if #(
  parameter int PIX_W = 8,
  parameter int CUR_N = 16,
  parameter int REF_N = 64
) ();
  logic                     start_i;
  logic [PIX_W-1:0]         pix_i;
  logic                     pix_valid_i;
  logic                     pix_ready_o;
  logic                     blk_valid_o;
  logic                     blk_ack_i;
  logic [$clog2(CUR_N)-1:0] cur_raddr_i;
  logic [PIX_W-1:0]         cur_rdata_o;
  logic [$clog2(REF_N)-1:0] ref_raddr_i;
  logic [PIX_W-1:0]         ref_rdata_o;
  logic                     busy_o;
  logic                     err_o;

  modport master (
    output start_i, pix_i, pix_valid_i, blk_ack_i, cur_raddr_i, ref_raddr_i,
    input  pix_ready_o, blk_valid_o, cur_rdata_o, ref_rdata_o, busy_o, err_o
  );

  modport slave (
    input  start_i, pix_i, pix_valid_i, blk_ack_i, cur_raddr_i, ref_raddr_i,
    output pix_ready_o, blk_valid_o, cur_rdata_o, ref_rdata_o, busy_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/mv_pixel_loader.sv
// ============================================================================
// Module   : mv_pixel_loader
// Brief    : Captures a 4x4 current block then an 8x8 search window and holds
//            them stable for the motion-vector search core until acknowledged.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mv_pixel_loader #(
  parameter int PIX_W = 8,
  parameter int CUR_N = 16,
  parameter int REF_N = 64
) (
  input  wire logic        wb_clk_i,
  input  wire logic        wb_rst_ni,
  mv_pixel_loader_if.slave bus
);

  localparam int CUR_AW = $clog2(CUR_N);
  localparam int CNT_W  = $clog2(REF_N);

  localparam logic [1:0] c_ST_IDLE     = 2'd0;
  localparam logic [1:0] c_ST_LOAD_CUR = 2'd1;
  localparam logic [1:0] c_ST_LOAD_REF = 2'd2;
  localparam logic [1:0] c_ST_READY    = 2'd3;

  localparam logic [CNT_W-1:0] c_CUR_LAST = CNT_W'(CUR_N - 1);
  localparam logic [CNT_W-1:0] c_REF_LAST = CNT_W'(REF_N - 1);

  logic [1:0]       r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             r_pix_ready, r_busy, r_blk_valid, r_err;
  logic             w_pix_ready_nx, w_busy_nx, w_blk_valid_nx, w_err_nx;
  logic             w_accept, w_cur_we, w_ref_we;

  logic [PIX_W-1:0] r_cur_mem [CUR_N];
  logic [PIX_W-1:0] r_ref_mem [REF_N];
  logic [PIX_W-1:0] r_cur_rdata, r_ref_rdata;

  assign w_accept = bus.pix_valid_i & r_pix_ready;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state     <= c_ST_IDLE;
      r_cnt       <= '0;
      r_pix_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_blk_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_pix_ready <= w_pix_ready_nx;
      r_busy      <= w_busy_nx;
      r_blk_valid <= w_blk_valid_nx;
      r_err       <= w_err_nx;
    end
  end

  // start_i outranks a pixel arriving in the same cycle: the pixel is dropped.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_err_nx   = 1'b0;
    w_cur_we   = 1'b0;
    w_ref_we   = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (bus.start_i) begin
          w_state_nx = c_ST_LOAD_CUR;
          w_cnt_nx   = '0;
        end
      end
      c_ST_LOAD_CUR: begin
        if (bus.start_i) begin
          w_cnt_nx = '0;
          w_err_nx = 1'b1;
        end else if (w_accept) begin
          w_cur_we = 1'b1;
          if (r_cnt == c_CUR_LAST) begin
            w_state_nx = c_ST_LOAD_REF;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      c_ST_LOAD_REF: begin
        if (bus.start_i) begin
          w_state_nx = c_ST_LOAD_CUR;
          w_cnt_nx   = '0;
          w_err_nx   = 1'b1;
        end else if (w_accept) begin
          w_ref_we = 1'b1;
          if (r_cnt == c_REF_LAST) begin
            w_state_nx = c_ST_READY;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      c_ST_READY: begin
        if (bus.blk_ack_i) begin
          w_state_nx = bus.start_i ? c_ST_LOAD_CUR : c_ST_IDLE;
          w_cnt_nx   = '0;
        end
      end
      default: begin
        w_state_nx = c_ST_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_pix_ready_nx = (w_state_nx == c_ST_LOAD_CUR) || (w_state_nx == c_ST_LOAD_REF);
    w_busy_nx      = (w_state_nx == c_ST_LOAD_CUR) || (w_state_nx == c_ST_LOAD_REF);
    w_blk_valid_nx = (w_state_nx == c_ST_READY);
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_cur_we) r_cur_mem[r_cnt[CUR_AW-1:0]] <= bus.pix_i;
    if (w_ref_we) r_ref_mem[r_cnt]             <= bus.pix_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cur_rdata <= '0;
      r_ref_rdata <= '0;
    end else begin
      r_cur_rdata <= r_cur_mem[bus.cur_raddr_i];
      r_ref_rdata <= r_ref_mem[bus.ref_raddr_i];
    end
  end

  assign bus.pix_ready_o = r_pix_ready;
  assign bus.busy_o      = r_busy;
  assign bus.blk_valid_o = r_blk_valid;
  assign bus.err_o       = r_err;
  assign bus.cur_rdata_o = r_cur_rdata;
  assign bus.ref_rdata_o = r_ref_rdata;

endmodule

`default_nettype wire
